// File: rtl/led_pkg.sv
// Shared types and helpers for the LED chain sequencer.
package led_pkg;

  typedef logic [23:0] rgb_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2,
    GAP   = 2'd3
  } seq_state_e;

  // Converts a duration in microseconds to clock cycles, never returning 0.
  function automatic int unsigned us_to_cycles(input int unsigned clk_freq,
                                               input int unsigned us);
    int unsigned cycles;
    cycles = (clk_freq / 32'd1_000_000) * us;
    return (cycles == 32'd0) ? 32'd1 : cycles;
  endfunction

  // Clamps an elaboration-time cycle count to at least one.
  function automatic int unsigned at_least_one(input int unsigned v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/led_refresh_timer.sv
// Free-running counter that emits a one-cycle tick every CYCLES clocks.
module led_refresh_timer #(
  parameter int unsigned CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (CYCLES > 32'd1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 32'd1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          tick_q;
  logic          tick_d;

  // Advance the counter and flag the wrap back to zero.
  always_comb begin
    if (cnt_q == LAST) begin
      cnt_d  = {CW{1'b0}};
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + CW'(1);
      tick_d = 1'b0;
    end
  end

  // Counter and tick registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= {CW{1'b0}};
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/led_chain_sequencer.sv
// Frame sequencer feeding a WS2812B led_driver: snapshots the on/off vector,
// streams one colour per LED over the ready/data_latched handshake, then
// holds the line idle for the latch gap before the next frame may start.
module led_chain_sequencer
  import led_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 27_000_000,
  parameter int unsigned NUM_LEDS   = 16,
  parameter rgb_t        COLOR_ON   = 24'h000f00,
  parameter rgb_t        COLOR_OFF  = 24'h000000,
  parameter int unsigned REFRESH_HZ = 100,
  parameter int unsigned GAP_US     = 300
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                update,
  input  logic [NUM_LEDS-1:0] states,
  output logic                frame_start,
  output logic                frame_done,
  output logic                drv_ready,
  output logic [23:0]         drv_rgb,
  input  logic                drv_busy,
  input  logic                drv_data_latched
);

  localparam int unsigned REFRESH_CYCLES = at_least_one(CLK_FREQ / REFRESH_HZ);
  localparam int unsigned GAP_CYCLES     = us_to_cycles(CLK_FREQ, GAP_US);
  localparam int unsigned IDX_W          = (NUM_LEDS > 32'd1) ? $clog2(NUM_LEDS) : 1;
  localparam int unsigned SH_W           = 2 ** IDX_W;
  localparam int unsigned GW             = $clog2(GAP_CYCLES + 32'd1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_LEDS - 32'd1);
  localparam logic [GW-1:0]    GAP_LOAD  = GW'(GAP_CYCLES);

  seq_state_e          state_q, state_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic [NUM_LEDS-1:0] shadow_q, shadow_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic                pending_q, pending_d;
  logic                drv_ready_q, drv_ready_d;
  rgb_t                drv_rgb_q, drv_rgb_d;
  logic                frame_start_q, frame_start_d;
  logic                frame_done_q, frame_done_d;

  logic                tick_s;
  logic                start_s;
  logic                last_s;
  logic [IDX_W-1:0]    next_idx_s;
  logic [SH_W-1:0]     shadow_pad_s;
  logic                next_bit_s;

  // Maps one on/off bit to its pixel colour.
  function automatic rgb_t colour(input logic on);
    return on ? COLOR_ON : COLOR_OFF;
  endfunction

  led_refresh_timer #(
    .CYCLES(REFRESH_CYCLES)
  ) u_refresh_timer (
    .clk (clk),
    .rst (rst),
    .tick(tick_s)
  );

  // Shadow is widened to a power of two so the next-bit select never leaves range.
  assign start_s      = (state_q == IDLE) && enable && pending_q && !drv_busy;
  assign last_s       = (index_q == LAST_IDX);
  assign next_idx_s   = index_q + IDX_W'(1);
  assign shadow_pad_s = SH_W'(shadow_q);
  assign next_bit_s   = shadow_pad_s[next_idx_s];

  // State register together with the datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      index_q       <= {IDX_W{1'b0}};
      shadow_q      <= {NUM_LEDS{1'b0}};
      gap_q         <= {GW{1'b0}};
      pending_q     <= 1'b0;
      drv_ready_q   <= 1'b0;
      drv_rgb_q     <= 24'h000000;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      shadow_q      <= shadow_d;
      gap_q         <= gap_d;
      pending_q     <= pending_d;
      drv_ready_q   <= drv_ready_d;
      drv_rgb_q     <= drv_rgb_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
    end
  end

  // Next state, pixel index, snapshot, gap countdown and request flag.
  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    shadow_d = shadow_q;
    gap_d    = gap_q;
    // A new request in the start cycle survives so it produces the next frame.
    if (tick_s || update) begin
      pending_d = 1'b1;
    end else if (start_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    case (state_q)
      IDLE: begin
        if (start_s) begin
          state_d  = SEND;
          index_d  = {IDX_W{1'b0}};
          shadow_d = states;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (drv_data_latched) begin
          if (last_s) begin
            state_d = DRAIN;
          end else begin
            index_d = next_idx_s;
          end
        end else begin
          state_d = SEND;
        end
      end
      DRAIN: begin
        if (!drv_busy) begin
          gap_d   = GAP_LOAD;
          state_d = GAP;
        end else begin
          state_d = DRAIN;
        end
      end
      GAP: begin
        if (gap_q <= GW'(1)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Driver handshake outputs and frame pulses for the next cycle.
  always_comb begin
    drv_ready_d   = drv_ready_q;
    drv_rgb_d     = drv_rgb_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          drv_ready_d   = 1'b1;
          drv_rgb_d     = colour(states[0]);
          frame_start_d = 1'b1;
        end else begin
          drv_ready_d = 1'b0;
        end
      end
      SEND: begin
        drv_ready_d = 1'b1;
        if (drv_data_latched) begin
          if (last_s) begin
            drv_ready_d = 1'b0;
          end else begin
            drv_rgb_d = colour(next_bit_s);
          end
        end else begin
          drv_rgb_d = drv_rgb_q;
        end
      end
      DRAIN: begin
        drv_ready_d = 1'b0;
      end
      GAP: begin
        drv_ready_d = 1'b0;
        if (gap_q <= GW'(1)) begin
          frame_done_d = 1'b1;
        end else begin
          frame_done_d = 1'b0;
        end
      end
      default: begin
        drv_ready_d = 1'b0;
      end
    endcase
  end

  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign drv_ready   = drv_ready_q;
  assign drv_rgb     = drv_rgb_q;

endmodule

// File: tb/tb_led_chain_sequencer.sv
// Bench for led_chain_sequencer: behavioural WS2812B driver models, a
// per-frame pixel scoreboard derived from the on/off snapshot, and directed
// plus randomized frames on a 4-LED and a 1-LED instance.
module tb_led_chain_sequencer;

  localparam logic [23:0] ON   = 24'h000f00;
  localparam logic [23:0] OFF  = 24'h000000;
  localparam int          GAP  = 5;
  localparam int          PIX  = 6;
  localparam int          DONE4 = 0, START4 = 1, LAT4 = 2, DONE1 = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en4 = 1'b0, upd4 = 1'b0, inj4 = 1'b0;
  logic [3:0]  st4 = 4'b0000;
  logic        fs4, fd4, rdy4;
  logic [23:0] rgb4;
  logic        en1 = 1'b0, upd1 = 1'b0;
  logic [0:0]  st1 = 1'b0;
  logic        fs1, fd1, rdy1;
  logic [23:0] rgb1;

  logic        mlat4 = 1'b0, mbusy4 = 1'b0, mlat1 = 1'b0, mbusy1 = 1'b0;
  logic [23:0] mcap4 = '0, mcap1 = '0;
  int          mcnt4 = 0, mcnt1 = 0;

  int errors = 0, checks = 0, cyc = 0;
  int nstart4 = 0, ndone4 = 0, nlat4 = 0, lif4 = 0, fall4 = 0;
  int ndone1 = 0, lif1 = 0, fall1 = 0;
  logic prev_busy4 = 1'b0, prev_busy1 = 1'b0;
  logic [23:0] exp4[$], exp1[$], seen4[$], seen1[$];
  logic [23:0] e;
  logic [23:0] want[4];
  int base;

  led_chain_sequencer #(
    .CLK_FREQ(1_000_000), .NUM_LEDS(4), .COLOR_ON(ON), .COLOR_OFF(OFF),
    .REFRESH_HZ(1000), .GAP_US(GAP)
  ) dut4 (
    .clk(clk), .rst(rst), .enable(en4), .update(upd4), .states(st4),
    .frame_start(fs4), .frame_done(fd4), .drv_ready(rdy4), .drv_rgb(rgb4),
    .drv_busy(mbusy4), .drv_data_latched(mlat4 | inj4)
  );

  led_chain_sequencer #(
    .CLK_FREQ(1_000_000), .NUM_LEDS(1), .COLOR_ON(ON), .COLOR_OFF(OFF),
    .REFRESH_HZ(1000), .GAP_US(GAP)
  ) dut1 (
    .clk(clk), .rst(rst), .enable(en1), .update(upd1), .states(st1),
    .frame_start(fs1), .frame_done(fd1), .drv_ready(rdy1), .drv_rgb(rgb1),
    .drv_busy(mbusy1), .drv_data_latched(mlat1)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string tag, input logic ok);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s: observed mismatch expected match", tag);
    end
  endfunction

  // Driver models: latch a pixel when ready and idle, then stay busy PIX cycles.
  always @(posedge clk) begin
    if (rst) begin
      mlat4 <= 1'b0; mbusy4 <= 1'b0; mcnt4 <= 0;
    end else if (mcnt4 == 0 && rdy4) begin
      mlat4 <= 1'b1; mcap4 <= rgb4; mcnt4 <= PIX; mbusy4 <= 1'b1;
    end else begin
      mlat4 <= 1'b0; mbusy4 <= (mcnt4 > 1);
      if (mcnt4 > 0) mcnt4 <= mcnt4 - 1;
    end
    if (rst) begin
      mlat1 <= 1'b0; mbusy1 <= 1'b0; mcnt1 <= 0;
    end else if (mcnt1 == 0 && rdy1) begin
      mlat1 <= 1'b1; mcap1 <= rgb1; mcnt1 <= PIX; mbusy1 <= 1'b1;
    end else begin
      mlat1 <= 1'b0; mbusy1 <= (mcnt1 > 1);
      if (mcnt1 > 0) mcnt1 <= mcnt1 - 1;
    end
  end

  // Scoreboard: expected pixels come from the states value present at frame start.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      exp4.delete(); exp1.delete(); lif4 = 0; lif1 = 0;
    end else begin
      if (fs4) begin
        nstart4++; lif4 = 0;
        for (int i = 0; i < 4; i++) exp4.push_back(st4[i] ? ON : OFF);
      end
      if (mlat4) begin
        lif4++; nlat4++; seen4.push_back(mcap4);
        chk("latch_within_frame4", exp4.size() > 0);
        if (exp4.size() > 0) begin
          e = exp4.pop_front();
          chk("pixel4", mcap4 === e);
        end
      end
      if (prev_busy4 && !mbusy4) fall4 = cyc;
      if (fd4) begin
        ndone4++;
        chk("latches_per_frame4", lif4 == 4);
        chk("gap_after_busy4", (cyc - fall4) == (GAP + 1));
      end
      if (fs1) begin
        lif1 = 0;
        exp1.push_back(st1[0] ? ON : OFF);
      end
      if (mlat1) begin
        lif1++; seen1.push_back(mcap1);
        chk("latch_within_frame1", exp1.size() > 0);
        if (exp1.size() > 0) begin
          e = exp1.pop_front();
          chk("pixel1", mcap1 === e);
        end
      end
      if (prev_busy1 && !mbusy1) fall1 = cyc;
      if (fd1) begin
        ndone1++;
        chk("latches_per_frame1", lif1 == 1);
        chk("gap_after_busy1", (cyc - fall1) == (GAP + 1));
      end
    end
    prev_busy4 = mbusy4;
    prev_busy1 = mbusy1;
  end

  function automatic int count_of(input int sel);
    case (sel)
      DONE4:   return ndone4;
      START4:  return nstart4;
      LAT4:    return nlat4;
      default: return ndone1;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (count_of(sel) < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, count_of(sel) >= target);
  endtask

  task automatic pulse_upd4();
    @(negedge clk) upd4 = 1'b1;
    @(negedge clk) upd4 = 1'b0;
  endtask

  task automatic check_seen4(input string tag);
    chk(tag, seen4.size() == 4);
    if (seen4.size() == 4) begin
      for (int i = 0; i < 4; i++) chk(tag, seen4[i] === want[i]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready4", rdy4 === 1'b0);
    chk("rst_rgb4", rgb4 === 24'h000000);
    chk("rst_fs4", fs4 === 1'b0);
    chk("rst_fd4", fd4 === 1'b0);
    chk("rst_ready1", rdy1 === 1'b0);
    rst = 1'b0;
    en4 = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_frame_without_request", nstart4 == 0);

    inj4 = 1'b1;
    @(negedge clk) inj4 = 1'b0;

    st4 = 4'b0101; seen4.delete();
    pulse_upd4();
    wait_for(DONE4, 1, 200, "t1_done");
    want = '{ON, OFF, ON, OFF};
    check_seen4("t1_pixels");

    st4 = 4'b0000; seen4.delete(); base = nlat4;
    pulse_upd4();
    wait_for(LAT4, base + 2, 200, "t2_two_latches");
    st4 = 4'b1111;
    wait_for(DONE4, 2, 200, "t2_done");
    want = '{OFF, OFF, OFF, OFF};
    check_seen4("t2_snapshot");
    seen4.delete();
    pulse_upd4();
    wait_for(DONE4, 3, 200, "t2_next_done");
    want = '{ON, ON, ON, ON};
    check_seen4("t2_next_frame");

    for (int k = 0; k < 5; k++) begin
      st4 = 4'($urandom);
      base = ndone4;
      pulse_upd4();
      wait_for(DONE4, base + 1, 200, "rand_done");
    end

    en4 = 1'b0; base = nstart4;
    repeat (3000) @(negedge clk);
    chk("t3_disabled_no_start", nstart4 == base);
    st4 = 4'($urandom); base = nlat4;
    en4 = 1'b1;
    wait_for(LAT4, base + 1, 200, "t3_first_latch");
    en4 = 1'b0;
    base = ndone4;
    wait_for(DONE4, base + 1, 200, "t3_frame_completes");
    base = nstart4;
    repeat (1500) @(negedge clk);
    chk("t3_no_start_after_disable", nstart4 == base);
    en4 = 1'b1; base = ndone4;
    wait_for(DONE4, base + 1, 200, "t3_pending_frame");

    base = nstart4;
    wait_for(START4, base + 1, 1200, "t4_tick_frame");
    st4 = 4'($urandom);
    repeat (3) pulse_upd4();
    wait_for(DONE4, ndone4 + 1, 200, "t4_first_done");
    wait_for(DONE4, ndone4 + 1, 200, "t4_second_done");
    chk("t4_one_extra_frame", nstart4 == base + 2);
    repeat (300) @(negedge clk);
    chk("t4_nothing_until_tick", nstart4 == base + 2);

    st4 = 4'($urandom); base = nlat4;
    pulse_upd4();
    wait_for(LAT4, base + 2, 200, "t5_two_latches");
    rst = 1'b1;
    #1;
    chk("t5_ready_async", rdy4 === 1'b0);
    chk("t5_fs_async", fs4 === 1'b0);
    chk("t5_fd_async", fd4 === 1'b0);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    base = nstart4;
    repeat (20) @(negedge clk);
    chk("t5_no_restart_without_request", nstart4 == base);
    st4 = 4'b0011; seen4.delete();
    pulse_upd4();
    wait_for(DONE4, ndone4 + 1, 200, "t5_done");
    want = '{ON, ON, OFF, OFF};
    check_seen4("t5_full_frame");

    en4 = 1'b0;
    st1 = 1'b1; en1 = 1'b1; seen1.delete();
    @(negedge clk) upd1 = 1'b1;
    @(negedge clk) upd1 = 1'b0;
    wait_for(DONE1, 1, 200, "t6_done");
    chk("t6_one_latch", seen1.size() == 1);
    if (seen1.size() > 0) chk("t6_pixel", seen1[0] === ON);
    en1 = 1'b0;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
